// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants for the PC redirect unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    SEQ      = 2'd0,
    WAIT_DS  = 2'd1,
    PEND_TGT = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  // Pair fetch advances to the next 8-byte boundary; an odd word realigns with +4.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc, input logic dual);
    return pc + (((dual == 1'b1) && (pc[2] == 1'b0)) ? 32'd8 : 32'd4);
  endfunction

endpackage

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with I-cache req/addr_ok handshake, MIPS delay-slot and exception redirects.
// Optional misaligned-PC detection is enabled by defining PC_ALIGN_CHECK_EN.
import fetch_pkg::*;

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit          DUAL_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_stall,
  input  logic        flush_exc,
  input  logic [31:0] exc_pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ds_fetched,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  output logic        fetch_single,
  output logic        fetch_discard,
  output logic        pc_adel
);

  logic [31:0] pc_r;
  logic [31:0] tgt_r;
  logic        hold_r;
  pc_state_t   state_r;

  logic [31:0] pc_s;
  logic [31:0] tgt_s;
  logic        hold_s;
  pc_state_t   state_s;
  logic        adel_s;
  logic        req_s;
  logic        accept_s;
  logic        single_s;
  logic        discard_s;

`ifdef PC_ALIGN_CHECK_EN
  assign adel_s = (pc_r[1:0] != 2'b00);
`else
  assign adel_s = 1'b0;
`endif

  // Request qualification; a stalled-but-raised request is kept alive by hold_r.
  assign req_s    = resetn & (~if_stall | hold_r) & ~flush_exc & ~adel_s;
  assign accept_s = req_s & inst_addr_ok;

  // Next-PC mux, redirect FSM and the per-accept fetch markers.
  always_comb begin
    pc_s      = pc_r;
    tgt_s     = tgt_r;
    state_s   = state_r;
    single_s  = 1'b0;
    discard_s = 1'b0;

    if (flush_exc) begin
      hold_s = 1'b0;
    end else if (accept_s) begin
      hold_s = 1'b0;
    end else if (req_s) begin
      hold_s = 1'b1;
    end else begin
      hold_s = hold_r;
    end

    if (flush_exc) begin
      pc_s    = exc_pc;
      state_s = SEQ;
    end else begin
      case (state_r)
        SEQ: begin
          if (br_valid) begin
            single_s  = accept_s & ~ds_fetched;
            discard_s = accept_s & ds_fetched;
            if (accept_s) begin
              pc_s = br_target;
            end else begin
              tgt_s   = br_target;
              state_s = ds_fetched ? PEND_TGT : WAIT_DS;
            end
          end else if (accept_s) begin
            pc_s = seq_next_pc(pc_r, DUAL_FETCH);
          end else begin
            pc_s = pc_r;
          end
        end
        WAIT_DS: begin
          single_s = accept_s;
          if (accept_s) begin
            pc_s    = tgt_r;
            state_s = SEQ;
          end else begin
            state_s = WAIT_DS;
          end
        end
        PEND_TGT: begin
          discard_s = accept_s;
          if (accept_s) begin
            pc_s    = tgt_r;
            state_s = SEQ;
          end else begin
            state_s = PEND_TGT;
          end
        end
        default: begin
          state_s = SEQ;
        end
      endcase
    end
  end

  // State registers; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r    <= RESET_PC;
      tgt_r   <= 32'd0;
      hold_r  <= 1'b0;
      state_r <= SEQ;
    end else begin
      pc_r    <= pc_s;
      tgt_r   <= tgt_s;
      hold_r  <= hold_s;
      state_r <= state_s;
    end
  end

  assign inst_req      = req_s;
  assign inst_addr     = pc_r;
  assign fetch_single  = single_s;
  assign fetch_discard = discard_s;
  assign pc_adel       = resetn & adel_s;

endmodule
